// File: rtl/br_pred_btb.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup, registered update.
// Optional gshare indexing of the counters is compiled in with BRPRED_GSHARE_EN.
module br_pred_btb #(
    parameter int unsigned NUM_INDEX_BIT = 3,
    parameter int unsigned TAG_BIT       = 8,
    parameter int unsigned ADDR_W        = 32,
    parameter logic [1:0]  INIT_STATE    = 2'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beq_i,
    input  logic              bne_i,
    input  logic [ADDR_W-1:0] ReadAddr_i,
    output logic [ADDR_W-1:0] ReadTarget_o,
    output logic              hit_o,
    input  logic              update_i,
    input  logic              branchTaken_i,
    input  logic [ADDR_W-1:0] WriteAddr_i,
    input  logic [ADDR_W-1:0] WriteTarget_i
);
    localparam int unsigned NUM_ENTRY = 2 ** NUM_INDEX_BIT;
    localparam int unsigned TAG_LO    = NUM_INDEX_BIT + 2;
    localparam int unsigned TAG_HI    = NUM_INDEX_BIT + TAG_BIT + 1;

    typedef enum logic [1:0] {
        NONTAKEN      = 2'd0,
        NEAR_NONTAKEN = 2'd1,
        NEAR_TAKEN    = 2'd2,
        TAKEN         = 2'd3
    } ctr_t;

    logic               valid   [NUM_ENTRY];
    logic [TAG_BIT-1:0] tags    [NUM_ENTRY];
    logic [ADDR_W-1:0]  targets [NUM_ENTRY];
    ctr_t               ctr     [NUM_ENTRY];

    logic [NUM_INDEX_BIT-1:0] rd_idx;
    logic [NUM_INDEX_BIT-1:0] wr_idx;
    logic [NUM_INDEX_BIT-1:0] rd_cidx;
    logic [NUM_INDEX_BIT-1:0] wr_cidx;
    logic [TAG_BIT-1:0]       rd_tag;
    logic [TAG_BIT-1:0]       wr_tag;
    logic                     rd_btb_hit;
    logic                     wr_btb_hit;
    logic                     is_branch;
    logic                     unused_addr_bits;

    assign rd_idx = ReadAddr_i[NUM_INDEX_BIT+1:2];
    assign wr_idx = WriteAddr_i[NUM_INDEX_BIT+1:2];
    assign rd_tag = ReadAddr_i[TAG_HI:TAG_LO];
    assign wr_tag = WriteAddr_i[TAG_HI:TAG_LO];

    // Only the index and tag fields of the PCs select entries; the rest is ignored.
    assign unused_addr_bits = ^{ReadAddr_i, WriteAddr_i};

`ifdef BRPRED_GSHARE_EN
    logic [NUM_INDEX_BIT-1:0] ghr;

    assign rd_cidx = rd_idx ^ ghr;
    assign wr_cidx = wr_idx ^ ghr;
`else
    assign rd_cidx = rd_idx;
    assign wr_cidx = wr_idx;
`endif

    assign rd_btb_hit = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign wr_btb_hit = valid[wr_idx] && (tags[wr_idx] == wr_tag);
    assign is_branch  = beq_i | bne_i;

    always_comb begin
        hit_o        = is_branch && rd_btb_hit && ctr[rd_cidx][1];
        ReadTarget_o = hit_o ? targets[rd_idx] : ReadAddr_i + ADDR_W'(4);
    end

    // Tag and target arrays are deliberately left out of reset; valid gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= ctr_t'(INIT_STATE);
            end
`ifdef BRPRED_GSHARE_EN
            ghr <= '0;
`endif
        end else if (update_i) begin
            if (wr_btb_hit) begin
                if (branchTaken_i) begin
                    if (ctr[wr_cidx] != TAKEN) begin
                        ctr[wr_cidx] <= ctr_t'(ctr[wr_cidx] + 2'd1);
                    end
                    targets[wr_idx] <= WriteTarget_i;
                end else if (ctr[wr_cidx] != NONTAKEN) begin
                    ctr[wr_cidx] <= ctr_t'(ctr[wr_cidx] - 2'd1);
                end
            end else if (branchTaken_i) begin
                valid[wr_idx]   <= 1'b1;
                tags[wr_idx]    <= wr_tag;
                targets[wr_idx] <= WriteTarget_i;
                ctr[wr_cidx]    <= NEAR_TAKEN;
            end
`ifdef BRPRED_GSHARE_EN
            ghr <= {ghr[NUM_INDEX_BIT-2:0], branchTaken_i};
`endif
        end
    end
endmodule
